// File: rtl/gf180mcu_osu_sc_gp12t3v3__segdrv_ctl.sv
// Ramped thermometer-code controller for NSEG inv_16 driver segments.
// Define GF180_SEGDRV_FAST_OFF_EN for a one-cycle hard turn-off instead of a ramp-down.
module gf180mcu_osu_sc_gp12t3v3__segdrv_ctl #(
  parameter int NSEG        = 8,
  parameter int STEP_CYCLES = 4
) (
  input  logic                        CLK,
  input  logic                        RN,
  input  logic                        EN,
  input  logic [$clog2(NSEG+1)-1:0]   LEVEL,
  output logic [NSEG-1:0]             SEG,
  output logic                        BUSY,
  output logic                        READY
);

  localparam int CW = $clog2(NSEG + 1);
  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] NSEG_C   = CW'(NSEG);
  localparam logic [TW-1:0] TMR_LAST = TW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] tgt;
  logic [CW-1:0] cnt_step;
  logic [TW-1:0] tmr;
  logic          fast_off;

  always_comb begin
    tgt = '0;
    if (EN) tgt = (LEVEL > NSEG_C) ? NSEG_C : LEVEL;
  end

  // One step toward the live target; direction is re-decided at every step edge.
  always_comb begin
    cnt_step = cnt;
    if (tgt > cnt)      cnt_step = cnt + CW'(1);
    else if (tgt < cnt) cnt_step = cnt - CW'(1);
  end

`ifdef GF180_SEGDRV_FAST_OFF_EN
  assign fast_off = (tgt == '0) && (state != IDLE);
`else
  assign fast_off = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
      cnt   <= '0;
      tmr   <= '0;
      BUSY  <= 1'b0;
      READY <= 1'b0;
    end else if (fast_off) begin
      state <= IDLE;
      cnt   <= '0;
      tmr   <= '0;
      BUSY  <= 1'b0;
      READY <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (tgt != cnt) begin
            state <= RAMP;
            tmr   <= '0;
            BUSY  <= 1'b1;
            READY <= 1'b0;
          end
        end
        RAMP: begin
          if (tmr == TMR_LAST) begin
            tmr <= '0;
            cnt <= cnt_step;
            if (cnt_step == tgt) begin
              state <= (tgt != '0) ? HOLD : IDLE;
              BUSY  <= 1'b0;
              READY <= (tgt != '0);
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          tmr   <= '0;
          BUSY  <= 1'b0;
          READY <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    SEG = '0;
    for (int i = 0; i < NSEG; i++) SEG[i] = (i < int'(cnt));
  end

endmodule
